// File: rtl/data_mem_responder.sv
// Multicycle load/store memory responder with fixed wait states,
// little-endian lane merging and sign/zero-extended load data.
module data_mem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        busy
);

   localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} fsmState;

   fsmState state, nextState;
   logic [3:0]  cnt, cntNext;

   logic        wrL, unsL;
   logic [31:0] addrL, wdataL;
   logic [1:0]  sizeL;

   logic        cWr, cUns;
   logic [31:0] cAddr, cWdata;
   logic [1:0]  cSize;

   logic          accept, enterResp, accessErr;
   logic [IW-1:0] wIdx;
   logic [31:0]   rdWord, shifted, loadData, laneData;
   logic [3:0]    be;

   logic [31:0] mem [DEPTH_WORDS];

   assign accept    = req_valid && (state == IDLE);
   assign req_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign resp_valid = (state == RESP);
   assign enterResp = (nextState == RESP) && (state != RESP);

   // With zero wait states the commit edge is also the accept edge,
   // so the live request is used instead of the latched copy.
   always_comb begin
      cWr    = wrL;
      cUns   = unsL;
      cAddr  = addrL;
      cWdata = wdataL;
      cSize  = sizeL;
      if (state == IDLE) begin
         cWr    = req_write;
         cUns   = req_unsigned;
         cAddr  = req_addr;
         cWdata = req_wdata;
         cSize  = req_size;
      end
   end

   always_comb begin
      accessErr = 1'b0;
      if (cSize == 2'b11) accessErr = 1'b1;
      if (cSize == 2'b01 && cAddr[0]) accessErr = 1'b1;
      if (cSize == 2'b10 && cAddr[1:0] != 2'b00) accessErr = 1'b1;
      if ({2'b00, cAddr[31:2]} >= 32'(DEPTH_WORDS)) accessErr = 1'b1;
   end

   assign wIdx    = cAddr[IW+1:2];
   assign rdWord  = mem[wIdx];
   assign shifted = rdWord >> {cAddr[1:0], 3'b000};

   always_comb begin
      be       = 4'b0000;
      laneData = cWdata;
      loadData = shifted;
      unique case (cSize)
         2'b00: begin
            be       = 4'b0001 << cAddr[1:0];
            laneData = {4{cWdata[7:0]}};
            loadData = cUns ? {24'b0, shifted[7:0]}
                            : {{24{shifted[7]}}, shifted[7:0]};
         end
         2'b01: begin
            be       = cAddr[1] ? 4'b1100 : 4'b0011;
            laneData = {2{cWdata[15:0]}};
            loadData = cUns ? {16'b0, shifted[15:0]}
                            : {{16{shifted[15]}}, shifted[15:0]};
         end
         default: begin
            be       = 4'b1111;
            laneData = cWdata;
            loadData = shifted;
         end
      endcase
   end

   always_comb begin
      nextState = state;
      cntNext   = cnt;
      unique case (state)
         IDLE: begin
            if (req_valid) begin
               if (WAIT_CYCLES == 0) begin
                  nextState = RESP;
               end else begin
                  nextState = WAIT;
                  cntNext   = 4'(WAIT_CYCLES - 1);
               end
            end
         end
         WAIT: begin
            if (cnt == 4'd0) nextState = RESP;
            else cntNext = cnt - 4'd1;
         end
         RESP: nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         wrL        <= 1'b0;
         unsL       <= 1'b0;
         addrL      <= 32'd0;
         wdataL     <= 32'd0;
         sizeL      <= 2'b00;
         resp_rdata <= 32'd0;
         resp_err   <= 1'b0;
      end else begin
         state <= nextState;
         cnt   <= cntNext;
         if (accept) begin
            wrL    <= req_write;
            unsL   <= req_unsigned;
            addrL  <= req_addr;
            wdataL <= req_wdata;
            sizeL  <= req_size;
         end
         if (enterResp) begin
            resp_err   <= accessErr;
            resp_rdata <= (accessErr || cWr) ? 32'd0 : loadData;
         end
      end
   end

   // Array is not reset; rst gating stops a commit while reset is held.
   always_ff @(posedge clk) begin
      if (enterResp && cWr && !accessErr && !rst) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[wIdx][8*i +: 8] <= laneData[8*i +: 8];
         end
      end
   end

endmodule
